// File: rtl/inversesubbytes.sv
// Combinational AES InvSubBytes over a full 128-bit state.
// Each byte is computed arithmetically: inverse affine map, then inversion in GF(2^8).
module inversesubbytes (
  input  logic [127:0] i_data,
  output logic [127:0] o_data
);

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = xtime(t);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse for a != 0 and maps 0 to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h01;
    p = a;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    logic [7:0] b;
    b = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
    return gf_inv(b);
  endfunction

  always_comb begin
    o_data = '0;
    for (int n = 0; n < 16; n++) begin
      o_data[127-8*n -: 8] = inv_sbox(i_data[127-8*n -: 8]);
    end
  end

endmodule

// File: rtl/aes256_inv_round_ctrl.sv
// Iterative AES-256 inverse cipher: one decryption round per clock over a 128-bit state,
// round keys fetched from an external key store with a 1-cycle registered read port.
module aes256_inv_round_ctrl #(
  parameter int unsigned NR    = 14,
  parameter int unsigned RK_AW = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [127:0]     ct_in,
  output logic             busy,
  output logic [RK_AW-1:0] rk_addr,
  input  logic [127:0]     rk_data,
  output logic [127:0]     pt_out,
  output logic             pt_valid
);

  typedef enum logic [2:0] {StIdle, StFetch, StInit, StRound, StFinal} state_e;

  state_e           r_fsm_q, w_fsm_d;
  logic [127:0]     r_blk_q, w_blk_d;
  logic [RK_AW-1:0] r_cnt_q, w_cnt_d;
  logic [RK_AW-1:0] r_rk_addr_q, w_rk_addr_d;
  logic [127:0]     r_pt_q, w_pt_d;
  logic             r_pt_valid_q, w_pt_valid_d;

  logic [127:0]     w_isr;
  logic [127:0]     w_isb;
  logic [127:0]     w_ark;
  logic [127:0]     w_imc;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // One column, {0e,0b,0d,09} circulant; a[0] is row 0.
  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [0:3][7:0] a, x2, x4, x8, m9, mb, md, me;
    a = col;
    for (int k = 0; k < 4; k++) begin
      x2[k] = xtime(a[k]);
      x4[k] = xtime(x2[k]);
      x8[k] = xtime(x4[k]);
      m9[k] = x8[k] ^ a[k];
      mb[k] = x8[k] ^ x2[k] ^ a[k];
      md[k] = x8[k] ^ x4[k] ^ a[k];
      me[k] = x8[k] ^ x4[k] ^ x2[k];
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  // Row r rotates right by r: out[r][c] = in[r][c-r].
  always_comb begin
    w_isr = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        w_isr[127-8*(4*c+r) -: 8] = r_blk_q[127-8*(4*((c+4-r)%4)+r) -: 8];
      end
    end
  end

  inversesubbytes u_inv_sub_bytes (
    .i_data (w_isr),
    .o_data (w_isb)
  );

  assign w_ark = w_isb ^ rk_data;

  always_comb begin
    w_imc = '0;
    for (int c = 0; c < 4; c++) begin
      w_imc[127-32*c -: 32] = inv_mix_col(w_ark[127-32*c -: 32]);
    end
  end

  always_comb begin
    w_fsm_d      = r_fsm_q;
    w_blk_d      = r_blk_q;
    w_cnt_d      = r_cnt_q;
    w_rk_addr_d  = r_rk_addr_q;
    w_pt_d       = r_pt_q;
    w_pt_valid_d = 1'b0;
    unique case (r_fsm_q)
      StIdle: begin
        // The state register doubles as the ciphertext latch until INIT.
        if (start) begin
          w_blk_d     = ct_in;
          w_rk_addr_d = RK_AW'(NR);
          w_fsm_d     = StFetch;
        end
      end
      StFetch: begin
        w_rk_addr_d = RK_AW'(NR - 1);
        w_fsm_d     = StInit;
      end
      StInit: begin
        w_blk_d     = r_blk_q ^ rk_data;
        w_cnt_d     = RK_AW'(NR - 1);
        w_rk_addr_d = RK_AW'(NR - 2);
        w_fsm_d     = StRound;
      end
      StRound: begin
        w_blk_d     = w_imc;
        w_cnt_d     = r_cnt_q - RK_AW'(1);
        w_rk_addr_d = (r_cnt_q >= RK_AW'(2)) ? (r_cnt_q - RK_AW'(2)) : '0;
        if (r_cnt_q == RK_AW'(1)) w_fsm_d = StFinal;
      end
      StFinal: begin
        w_pt_d       = w_ark;
        w_pt_valid_d = 1'b1;
        w_fsm_d      = StIdle;
      end
      default: w_fsm_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fsm_q      <= StIdle;
      r_blk_q      <= '0;
      r_cnt_q      <= '0;
      r_rk_addr_q  <= '0;
      r_pt_q       <= '0;
      r_pt_valid_q <= 1'b0;
    end else begin
      r_fsm_q      <= w_fsm_d;
      r_blk_q      <= w_blk_d;
      r_cnt_q      <= w_cnt_d;
      r_rk_addr_q  <= w_rk_addr_d;
      r_pt_q       <= w_pt_d;
      r_pt_valid_q <= w_pt_valid_d;
    end
  end

  assign busy     = (r_fsm_q != StIdle);
  assign rk_addr  = r_rk_addr_q;
  assign pt_out   = r_pt_q;
  assign pt_valid = r_pt_valid_q;

endmodule

// File: tb/tb_aes256_inv_round_ctrl.sv
// Bench for aes256_inv_round_ctrl: known-answer table, timing corner cases and
// random blocks encrypted by a forward AES-256 reference model.
module tb_aes256_inv_round_ctrl;

  localparam int unsigned NR    = 14;
  localparam int unsigned RK_AW = 4;
  localparam int          LAT   = 17;
  localparam int          NV    = 4;

  typedef logic [14:0][127:0] rks_t;
  typedef struct packed {
    logic [255:0] key;
    logic [127:0] ct;
    logic [127:0] pt;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [127:0]     ct_in;
  logic             busy;
  logic [RK_AW-1:0] rk_addr;
  logic [127:0]     rk_data;
  logic [127:0]     pt_out;
  logic             pt_valid;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] sbox_tab [256];
  rks_t       rk_cur;

  always #5 clk = ~clk;

  aes256_inv_round_ctrl #(
    .NR    (NR),
    .RK_AW (RK_AW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .ct_in    (ct_in),
    .busy     (busy),
    .rk_addr  (rk_addr),
    .rk_data  (rk_data),
    .pt_out   (pt_out),
    .pt_valid (pt_valid)
  );

  // Key store with one cycle of read latency.
  always_ff @(posedge clk) begin
    rk_data <= (rk_addr <= RK_AW'(NR)) ? rk_cur[rk_addr] : '0;
  end

  // ---------------- forward AES-256 reference ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = xt(t);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int k);
    return (v << k) | (v >> (8 - k));
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] t);
    return {sbox_tab[t[31:24]], sbox_tab[t[23:16]], sbox_tab[t[15:8]], sbox_tab[t[7:0]]};
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = sbox_tab[s[127-8*i -: 8]];
    return o;
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] mix_cols(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
      o[103-32*c -: 8] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
    end
    return o;
  endfunction

  function automatic rks_t expand(input logic [255:0] key);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    rks_t        rks;
    rc = 8'h01;
    for (int i = 0; i < 8; i++) w[i] = key[255-32*i -: 32];
    for (int i = 8; i < 60; i++) begin
      t = w[i-1];
      if (i % 8 == 0) begin
        t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (i % 8 == 4) begin
        t = sub_word(t);
      end
      w[i] = w[i-8] ^ t;
    end
    for (int r = 0; r < 15; r++) rks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return rks;
  endfunction

  function automatic logic [127:0] aes_enc(input logic [255:0] key, input logic [127:0] pt);
    rks_t         rks;
    logic [127:0] s;
    rks = expand(key);
    s   = pt ^ rks[0];
    for (int r = 1; r < 14; r++) s = mix_cols(shift_rows(sub_bytes(s))) ^ rks[r];
    return shift_rows(sub_bytes(s)) ^ rks[14];
  endfunction

  // ---------------- bench helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic load_key(input logic [255:0] key);
    rk_cur = expand(key);
  endtask

  // Pulses start for one cycle and waits (bounded) for pt_valid; pt_out must hold `held` meanwhile.
  task automatic launch(input logic [127:0] ct, input logic [127:0] held,
                        output int lat, output int hold_bad);
    start    = 1'b1;
    ct_in    = ct;
    lat      = 0;
    hold_bad = 0;
    for (int n = 1; n <= 40; n++) begin
      tick();
      start = 1'b0;
      if (pt_valid === 1'b1) begin
        lat = n;
        break;
      end
      if (pt_out !== held) hold_bad++;
    end
  endtask

  initial begin
    vec_t         vecs [NV];
    int           lat, hb, busy_cnt, valid_cnt, hold_total;
    logic [127:0] prev_pt, ct2, pt2, rpt, rct;
    logic [255:0] rkey;
    logic [7:0]   inv;

    rst     = 1'b1;
    start   = 1'b0;
    ct_in   = '0;
    rk_cur  = '0;

    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_tab[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end

    vecs[0] = '{key: 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
                ct:  128'h8ea2b7ca516745bfeafc49904b496089,
                pt:  128'h00112233445566778899aabbccddeeff};
    vecs[1] = '{key: 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4,
                ct:  128'hf3eed1bdb5d2a03c064b5a7e3db181f8,
                pt:  128'h6bc1bee22e409f96e93d7e117393172a};
    vecs[2] = '{key: 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4,
                ct:  128'h591ccb10d410ed26dc5ba74a31362870,
                pt:  128'hae2d8a571e03ac9c9eb76fac45af8e51};
    vecs[3] = '{key: 256'h0,
                ct:  128'hdc95c078a2408989ad48a21492842087,
                pt:  128'h0};

    // Reset state
    tick();
    tick();
    chk("reset_busy", 128'(busy), 128'(0));
    chk("reset_pt_valid", 128'(pt_valid), 128'(0));
    chk("reset_pt_out", pt_out, 128'(0));
    chk("reset_rk_addr", 128'(rk_addr), 128'(0));
    rst = 1'b0;
    tick();
    chk("idle_busy", 128'(busy), 128'(0));

    // FIPS-197 C.3 with full rk_addr / busy trace
    load_key(vecs[0].key);
    start     = 1'b1;
    ct_in     = vecs[0].ct;
    busy_cnt  = 0;
    valid_cnt = 0;
    lat       = 0;
    for (int n = 1; n <= 20; n++) begin
      tick();
      start = 1'b0;
      ct_in = {$urandom, $urandom, $urandom, $urandom};
      chk($sformatf("rk_addr_cycle%0d", n), 128'(rk_addr), 128'((n <= 15) ? 15 - n : 0));
      if (busy === 1'b1) busy_cnt++;
      if (pt_valid === 1'b1) begin
        valid_cnt++;
        lat = n;
      end
    end
    chk_int("c3_latency", lat, LAT);
    chk_int("c3_valid_pulses", valid_cnt, 1);
    chk_int("c3_busy_cycles", busy_cnt, 16);
    chk("c3_pt_held", pt_out, vecs[0].pt);
    prev_pt = vecs[0].pt;

    // Known-answer table
    for (int i = 0; i < NV; i++) begin
      load_key(vecs[i].key);
      launch(vecs[i].ct, prev_pt, lat, hb);
      chk_int($sformatf("vec%0d_latency", i), lat, LAT);
      chk_int($sformatf("vec%0d_hold", i), hb, 0);
      chk($sformatf("vec%0d_pt", i), pt_out, vecs[i].pt);
      tick();
      chk($sformatf("vec%0d_valid_drop", i), 128'(pt_valid), 128'(0));
      chk($sformatf("vec%0d_pt_after", i), pt_out, vecs[i].pt);
      prev_pt = vecs[i].pt;
    end

    // start held high through busy with ct_in changing
    load_key(vecs[0].key);
    start = 1'b1;
    ct_in = vecs[0].ct;
    lat   = 0;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (pt_valid === 1'b1) begin
        start = 1'b0;
        lat   = n;
        break;
      end
      ct_in = {$urandom, $urandom, $urandom, $urandom};
    end
    chk_int("held_start_latency", lat, LAT);
    chk("held_start_pt", pt_out, vecs[0].pt);
    valid_cnt = 0;
    busy_cnt  = 0;
    for (int n = 0; n < 20; n++) begin
      tick();
      if (pt_valid === 1'b1) valid_cnt++;
      if (busy === 1'b1) busy_cnt++;
    end
    chk_int("held_start_single_result", valid_cnt, 0);
    chk_int("held_start_no_reaccept", busy_cnt, 0);
    prev_pt = vecs[0].pt;

    // Back-to-back: second start in the pt_valid cycle
    pt2 = {$urandom, $urandom, $urandom, $urandom};
    ct2 = aes_enc(vecs[1].key, pt2);
    load_key(vecs[1].key);
    launch(vecs[1].ct, prev_pt, lat, hb);
    chk("b2b_first_pt", pt_out, vecs[1].pt);
    launch(ct2, vecs[1].pt, lat, hb);
    chk_int("b2b_second_latency", lat, LAT);
    chk_int("b2b_first_held", hb, 0);
    chk("b2b_second_pt", pt_out, pt2);

    // Reset in the middle of ROUND
    start = 1'b1;
    ct_in = ct2;
    tick();
    start = 1'b0;
    for (int n = 2; n <= 8; n++) tick();
    chk("mid_busy_before_rst", 128'(busy), 128'(1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_pt_valid", 128'(pt_valid), 128'(0));
    chk("rst_pt_out", pt_out, 128'(0));
    chk("rst_rk_addr", 128'(rk_addr), 128'(0));
    valid_cnt = 0;
    for (int n = 0; n < 20; n++) begin
      tick();
      if (pt_valid === 1'b1) valid_cnt++;
    end
    chk_int("rst_no_valid", valid_cnt, 0);
    prev_pt = '0;

    // Random keys and plaintexts through the reference model
    hold_total = 0;
    for (int b = 0; b < 1000; b++) begin
      rkey = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      rpt  = {$urandom, $urandom, $urandom, $urandom};
      rct  = aes_enc(rkey, rpt);
      load_key(rkey);
      launch(rct, prev_pt, lat, hb);
      hold_total += hb;
      chk_int($sformatf("rand%0d_latency", b), lat, LAT);
      chk($sformatf("rand%0d_pt", b), pt_out, rpt);
      prev_pt = rpt;
    end
    chk_int("rand_hold", hold_total, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
